// File: rtl/dest_tag_pipe.sv
// Destination-register tag pipeline D->X->M->W feeding the hazard unit, with
// bubble insertion on stall/flush, saturating event counters and a stall watchdog.
module dest_tag_pipe #(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_wr_en,
  input  logic             d_read_mem,
  input  logic             stall_d,
  input  logic             flush,
  output logic [REG_W-1:0] x_rd,
  output logic             x_read_mem,
  output logic [REG_W-1:0] m_rd,
  output logic             m_read_mem,
  output logic [REG_W-1:0] w_rd,
  output logic             w_wr_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  localparam logic [7:0]       RUN_LIMIT = 8'(MAX_STALL);
  localparam logic [7:0]       RUN_MAX   = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [REG_W-1:0] d_tag;
  logic             d_ld;
  logic             bubble;
  logic             stall_only;
  logic [7:0]       run_cnt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    d_tag      = '0;
    d_ld       = 1'b0;
    if (d_valid && d_wr_en) begin
      d_tag = d_rd;
      d_ld  = d_read_mem;
    end
    bubble     = stall_d | flush;
    // A flush that coincides with a stall is accounted as a flush only.
    stall_only = stall_d & ~flush;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_rd       <= '0;
      x_read_mem <= 1'b0;
      m_rd       <= '0;
      m_read_mem <= 1'b0;
      w_rd       <= '0;
    end else begin
      x_rd       <= bubble ? '0 : d_tag;
      x_read_mem <= bubble ? 1'b0 : d_ld;
      m_rd       <= x_rd;
      m_read_mem <= x_read_mem;
      w_rd       <= m_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_only && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != CNT_MAX)      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Run counter holds the number of consecutive stall cycles already seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt   <= '0;
      stall_err <= 1'b0;
    end else if (stall_only) begin
      if (run_cnt >= RUN_LIMIT) stall_err <= 1'b1;
      if (run_cnt != RUN_MAX)   run_cnt   <= run_cnt + 8'd1;
    end else begin
      run_cnt <= '0;
    end
  end

  assign w_wr_en = (w_rd != '0);

endmodule

// File: tb/tb_dest_tag_pipe.sv
// Self-checking bench for dest_tag_pipe: directed sequences, a vector table and
// randomized traffic compared against a stage-list reference model.
module tb_dest_tag_pipe;

  localparam int REG_W     = 5;
  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 8;
  localparam int CMAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             d_valid, d_wr_en, d_read_mem, stall_d, flush;
  logic [REG_W-1:0] d_rd;
  logic [REG_W-1:0] x_rd, m_rd, w_rd;
  logic             x_read_mem, m_read_mem, w_wr_en, stall_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  dest_tag_pipe #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rd(d_rd), .d_wr_en(d_wr_en),
    .d_read_mem(d_read_mem), .stall_d(stall_d), .flush(flush),
    .x_rd(x_rd), .x_read_mem(x_read_mem), .m_rd(m_rd), .m_read_mem(m_read_mem),
    .w_rd(w_rd), .w_wr_en(w_wr_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, index 0 = X, 1 = M, 2 = W.
  typedef struct {int tag; bit ld;} stage_t;
  stage_t mq[3];
  int     m_stall, m_flush, m_run;
  bit     m_err;

  typedef struct {
    bit valid; int rd; bit wr; bit rmem; bit stall; bit fl;
    int exp_x; bit exp_ld;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) mq[i] = '{0, 1'b0};
    m_stall = 0; m_flush = 0; m_run = 0; m_err = 1'b0;
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    stage_t nw;
    if (!rst_n) begin model_clear(); return; end
    nw = '{0, 1'b0};
    if (d_valid && d_wr_en && !stall_d && !flush) nw = '{int'(d_rd), d_read_mem};
    mq[2] = mq[1]; mq[1] = mq[0]; mq[0] = nw;
    if (flush) m_flush = (m_flush >= CMAX) ? CMAX : m_flush + 1;
    if (stall_d && !flush) begin
      m_stall = (m_stall >= CMAX) ? CMAX : m_stall + 1;
      m_run++;
      if (m_run > MAX_STALL) m_err = 1'b1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".x_rd"},       int'(x_rd),       mq[0].tag);
    check({tag, ".x_read_mem"}, int'(x_read_mem), int'(mq[0].ld));
    check({tag, ".m_rd"},       int'(m_rd),       mq[1].tag);
    check({tag, ".m_read_mem"}, int'(m_read_mem), int'(mq[1].ld));
    check({tag, ".w_rd"},       int'(w_rd),       mq[2].tag);
    check({tag, ".w_wr_en"},    int'(w_wr_en),    int'(mq[2].tag != 0));
    check({tag, ".stall_cnt"},  int'(stall_cnt),  m_stall);
    check({tag, ".flush_cnt"},  int'(flush_cnt),  m_flush);
    check({tag, ".stall_err"},  int'(stall_err),  int'(m_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".x_rd"},       int'(x_rd), 0);
    check({tag, ".x_read_mem"}, int'(x_read_mem), 0);
    check({tag, ".m_rd"},       int'(m_rd), 0);
    check({tag, ".m_read_mem"}, int'(m_read_mem), 0);
    check({tag, ".w_rd"},       int'(w_rd), 0);
    check({tag, ".w_wr_en"},    int'(w_wr_en), 0);
    check({tag, ".stall_cnt"},  int'(stall_cnt), 0);
    check({tag, ".flush_cnt"},  int'(flush_cnt), 0);
    check({tag, ".stall_err"},  int'(stall_err), 0);
  endtask

  task automatic drive(input bit v, input int rd, input bit wr, input bit rm,
                       input bit st, input bit fl);
    d_valid = v; d_rd = REG_W'(rd); d_wr_en = wr; d_read_mem = rm;
    stall_d = st; flush = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b0,  0, 1'b0},
      '{1'b0,  9, 1'b1, 1'b1, 1'b0, 1'b0,  0, 1'b0},
      '{1'b1,  0, 1'b1, 1'b0, 1'b0, 1'b0,  0, 1'b0},
      '{1'b1, 17, 1'b1, 1'b1, 1'b0, 1'b0, 17, 1'b1},
      '{1'b1, 22, 1'b1, 1'b0, 1'b1, 1'b0,  0, 1'b0},
      '{1'b1, 22, 1'b1, 1'b1, 1'b0, 1'b1,  0, 1'b0},
      '{1'b1, 31, 1'b1, 1'b0, 1'b0, 1'b0, 31, 1'b0},
      '{1'b0, 31, 1'b0, 1'b1, 1'b0, 1'b0,  0, 1'b0}
    };
    drive(1, 6, 1, 1, 1, 1);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_clear();
    #1 check_all_zero("rst_hold");
    tick();
    check_all_zero("rst_edge");
    rst_n = 1'b1;

    // Latency: tags 3, 7, 9 back to back.
    drive(1, 3, 1, 0, 0, 0); tick(); check("lat.x0", int'(x_rd), 3);
    drive(1, 7, 1, 0, 0, 0); tick(); check("lat.x1", int'(x_rd), 7); check("lat.m0", int'(m_rd), 3);
    drive(1, 9, 1, 0, 0, 0); tick(); check("lat.x2", int'(x_rd), 9);
    check("lat.w0", int'(w_rd), 3); check("lat.wen0", int'(w_wr_en), 1);
    drive(0, 0, 0, 0, 0, 0); tick(); check("lat.w1", int'(w_rd), 7);
    tick(); check("lat.w2", int'(w_rd), 9); check("lat.wen2", int'(w_wr_en), 1);
    compare_all("lat");

    // Load-use stall: load r5 then one stall cycle holding r6 in D.
    do_reset();
    drive(1, 5, 1, 1, 0, 0); tick();
    check("ld.x", int'(x_rd), 5); check("ld.x_ld", int'(x_read_mem), 1);
    drive(1, 6, 1, 0, 1, 0); tick();
    check("ld.bubble_x", int'(x_rd), 0); check("ld.m", int'(m_rd), 5);
    check("ld.m_ld", int'(m_read_mem), 1); check("ld.stall_cnt", int'(stall_cnt), 1);
    drive(1, 6, 1, 0, 0, 0); tick();
    check("ld.held_x", int'(x_rd), 6); check("ld.bubble_m", int'(m_rd), 0);
    check("ld.w", int'(w_rd), 5);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("ld.bubble_w", int'(w_rd), 0); check("ld.stall_cnt2", int'(stall_cnt), 1);
    compare_all("ld");

    // Flush and stall together.
    do_reset();
    drive(1, 4, 1, 0, 1, 1); tick();
    check("fs.x", int'(x_rd), 0);
    check("fs.flush_cnt", int'(flush_cnt), 1); check("fs.stall_cnt", int'(stall_cnt), 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    compare_all("fs");

    // Vector table, including writes to r0 checked again when they reach W.
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].rmem, vecs[i].stall, vecs[i].fl);
      tick();
      check($sformatf("vec%0d.x_rd", i), int'(x_rd), vecs[i].exp_x);
      check($sformatf("vec%0d.x_ld", i), int'(x_read_mem), int'(vecs[i].exp_ld));
      compare_all($sformatf("vec%0d", i));
    end
    do_reset();
    drive(1, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick(); tick();
    check("r0.w_wr_en", int'(w_wr_en), 0);

    // Watchdog: 8 stall cycles are tolerated, the 9th trips it.
    do_reset();
    drive(1, 2, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) tick();
    check("wd.err8", int'(stall_err), 0);
    tick();
    check("wd.err9", int'(stall_err), 1);
    drive(1, 2, 1, 0, 0, 0);
    tick(); tick();
    check("wd.sticky", int'(stall_err), 1);
    compare_all("wd");
    do_reset();
    check("wd.cleared", int'(stall_err), 0);

    // Counter saturation at 2^CNT_W-1.
    drive(1, 2, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick();
    check("sat.stall_cnt", int'(stall_cnt), CMAX);
    compare_all("sat");

    // Asynchronous reset pulse between edges.
    drive(1, 8, 1, 1, 0, 0); tick(); tick();
    #2 rst_n = 1'b0;
    model_clear();
    #1 check_all_zero("arst");
    #1 rst_n = 1'b1;
    tick();
    compare_all("arst_rel");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      if ((i % 50) > 30 && (i % 50) < 42) begin stall_d = 1'b1; flush = 1'b0; end
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n) model_clear();
      tick();
      compare_all($sformatf("rnd%0d", i));
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
